// File: rtl/mutual_excl_system.sv
// N-node mutual-exclusion protocol (Idle/Try/Crit/Exit) sharing one token.
// One selector-chosen guarded rule fires per clock; a safety flag is exported.
module mutual_excl_system #(
  parameter int NUM_NODES = 3,
  parameter int EN_WIDTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [EN_WIDTH-1:0]    io_en_a,
  output logic [2*NUM_NODES-1:0] io_n,
  output logic                   io_x,
  output logic                   io_fired,
  output logic                   io_inv_ok
);

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_T = 2'd1;
  localparam logic [1:0] ST_C = 2'd2;
  localparam logic [1:0] ST_E = 2'd3;

  logic [2*NUM_NODES-1:0] n_q, n_d;
  logic                   x_q, x_d;
  logic                   fired_q, fired_d;
  int                     r;
  int                     busy;

  // Registered protocol state; reset drops straight back to init.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      n_q     <= '0;
      x_q     <= 1'b1;
      fired_q <= 1'b0;
    end else begin
      n_q     <= n_d;
      x_q     <= x_d;
      fired_q <= fired_d;
    end
  end

  // Decode the selector into one rule instance and apply it if its guard holds.
  always_comb begin
    n_d     = n_q;
    x_d     = x_q;
    fired_d = 1'b0;
    r       = 32'(io_en_a);
    for (int i = 0; i < NUM_NODES; i++) begin
      unique case (1'b1)
        (r == i): begin
          if (n_q[2*i +: 2] == ST_I) begin
            n_d[2*i +: 2] = ST_T;
            fired_d       = 1'b1;
          end
        end
        (r == NUM_NODES + i): begin
          if (n_q[2*i +: 2] == ST_T && x_q) begin
            n_d[2*i +: 2] = ST_C;
            x_d           = 1'b0;
            fired_d       = 1'b1;
          end
        end
        (r == 2*NUM_NODES + i): begin
          if (n_q[2*i +: 2] == ST_C) begin
            n_d[2*i +: 2] = ST_E;
            fired_d       = 1'b1;
          end
        end
        (r == 3*NUM_NODES + i): begin
          if (n_q[2*i +: 2] == ST_E) begin
            n_d[2*i +: 2] = ST_I;
            x_d           = 1'b1;
            fired_d       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Safety: at most one node in C/E, and a free token means none are.
  always_comb begin
    busy = 0;
    for (int i = 0; i < NUM_NODES; i++) begin
      if (n_q[2*i+1]) busy = busy + 1;
    end
    io_inv_ok = (busy <= 1) && !(x_q && busy != 0);
  end

  assign io_n     = n_q;
  assign io_x     = x_q;
  assign io_fired = fired_q;

endmodule

// File: tb/tb_mutual_excl_system.sv
// Directed table of rule selections with hand-computed results,
// plus mid-operation reset and random selector stress on the safety flag.
module tb_mutual_excl_system;

  logic       clock;
  logic       reset;
  logic [3:0] io_en_a;
  logic [5:0] io_n;
  logic       io_x;
  logic       io_fired;
  logic       io_inv_ok;

  int compared;
  int mismatched;

  mutual_excl_system #(.NUM_NODES(3), .EN_WIDTH(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .io_en_a  (io_en_a),
    .io_n     (io_n),
    .io_x     (io_x),
    .io_fired (io_fired),
    .io_inv_ok(io_inv_ok)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [3:0] en;
    logic [5:0] n;
    logic       x;
    logic       fired;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] en);
    @(negedge clock);
    io_en_a = en;
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string name, input logic [5:0] n,
                             input logic x, input logic f);
    check({name, ".n"}, 32'(io_n), 32'(n));
    check({name, ".x"}, 32'(io_x), 32'(x));
    check({name, ".fired"}, 32'(io_fired), 32'(f));
    check({name, ".inv"}, 32'(io_inv_ok), 32'd1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    io_en_a    = 4'd12;
    reset      = 1'b1;

    vecs.push_back('{"idle0",   4'd12, 6'h00, 1'b1, 1'b0});
    vecs.push_back('{"idle1",   4'd12, 6'h00, 1'b1, 1'b0});
    vecs.push_back('{"idle2",   4'd15, 6'h00, 1'b1, 1'b0});
    vecs.push_back('{"try1",    4'd1,  6'h04, 1'b1, 1'b1});
    vecs.push_back('{"crit1",   4'd4,  6'h08, 1'b0, 1'b1});
    vecs.push_back('{"exit1",   4'd7,  6'h0C, 1'b0, 1'b1});
    vecs.push_back('{"idl1",    4'd10, 6'h00, 1'b1, 1'b1});
    vecs.push_back('{"noexit0", 4'd6,  6'h00, 1'b1, 1'b0});
    vecs.push_back('{"noidle0", 4'd9,  6'h00, 1'b1, 1'b0});
    vecs.push_back('{"try0",    4'd0,  6'h01, 1'b1, 1'b1});
    vecs.push_back('{"try1b",   4'd1,  6'h05, 1'b1, 1'b1});
    vecs.push_back('{"crit0",   4'd3,  6'h06, 1'b0, 1'b1});
    vecs.push_back('{"blocked", 4'd4,  6'h06, 1'b0, 1'b0});
    vecs.push_back('{"retry1",  4'd1,  6'h06, 1'b0, 1'b0});
    vecs.push_back('{"exit0",   4'd6,  6'h07, 1'b0, 1'b1});
    vecs.push_back('{"idle0b",  4'd9,  6'h04, 1'b1, 1'b1});
    vecs.push_back('{"try2",    4'd2,  6'h14, 1'b1, 1'b1});
    vecs.push_back('{"crit2",   4'd5,  6'h24, 1'b0, 1'b1});

    // Asynchronous reset without any clock edge.
    #2 reset = 1'b0;
    #1;
    check_state("reset", 6'h00, 1'b1, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[k]) begin
      step(vecs[k].en);
      check_state(vecs[k].name, vecs[k].n, vecs[k].x, vecs[k].fired);
    end

    // Node 2 in C with fired=1: pulse reset between edges.
    io_en_a = 4'd12;
    #2 reset = 1'b0;
    #1;
    check_state("midrst", 6'h00, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    check_state("rsthold", 6'h00, 1'b1, 1'b0);
    @(negedge clock);
    io_en_a = 4'd0;
    reset   = 1'b1;
    @(posedge clock);
    #1;
    check_state("firstrule", 6'h01, 1'b1, 1'b1);

    // Random selector stress: safety flag must never drop.
    for (int c = 0; c < 10000; c++) begin
      step(4'($urandom_range(0, 15)));
      check("stress.inv", 32'(io_inv_ok), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mutual_excl_system.md
Name: mutual_excl_system

Overview:
- Synthesizable model of the classic N-node mutual-exclusion protocol: each node cycles Idle -> Try -> Crit -> Exit -> Idle.
- A single shared token bit `x` grants entry to the critical section.
- Each cycle an external selector `io_en_a` picks at most one guarded rule instance to fire.
- Used as the design under formal and simulation equivalence checking against the protocol model. It exposes its state and a safety flag for checkers.

Parameters:
- NUM_NODES, 3, number of protocol nodes.
- EN_WIDTH, 4, width of the rule selector. Must satisfy 2^EN_WIDTH >= 4*NUM_NODES.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces the init state immediately.
- io_en_a  input  EN_WIDTH  rule-instance selector, sampled on the rising edge.
- io_n  output  2*NUM_NODES  packed node states; node i occupies bits [2i+1:2i].
- io_x  output  1  shared token (1 = critical section free).
- io_fired  output  1  registered: 1 if the rule selected in the previous cycle had a true guard and was applied.
- io_inv_ok  output  1  combinational safety flag: 1 when at most one node is in C or E, and x=1 implies no node is in C or E.

Behaviour:
- Node state encoding, 2 bits: I=0, T=1, C=2, E=3.
- Init/reset values (asynchronous, while reset=0): every n[i]=I, x=1, io_fired=0. State is held in init while reset is low.
- Rule index r = io_en_a. With N = NUM_NODES, indices map as follows:
  - r in [0, N): Try node r. Guard n[r]=I. Action n[r]:=T.
  - r in [N, 2N): Crit node i=r-N. Guard n[i]=T and x=1. Action n[i]:=C, x:=0.
  - r in [2N, 3N): Exit node i=r-2N. Guard n[i]=C. Action n[i]:=E.
  - r in [3N, 4N): Idle node i=r-3N. Guard n[i]=E. Action n[i]:=I, x:=1.
  - r >= 4N (12..15 for the defaults): no-op.
- Firing rules:
  - Exactly zero or one rule fires per cycle; there is no concurrency between nodes.
  - Guard false: all state holds and io_fired<=0 next cycle.
  - Guard true: updates take effect at the next rising edge and io_fired<=1.
- Latency: one cycle from the selector to the state change. io_n and io_x are driven directly from the registers.
- io_inv_ok is combinational from the registers.
  - From the init state, under any selector sequence, io_inv_ok must remain 1. This is the checked safety property.
  - The RTL must not force io_inv_ok; it is computed only from the registers.
- Reset mid-operation: an asynchronous return to init regardless of the clock. There is no partial update on the edge coincident with reset release. The first rule is applied on the first rising edge with reset=1.
- Selector values of X/undefined are not permitted. Out-of-range values (r >= 4N) are no-ops.

Test Plan:
- Reset: reset=0 with arbitrary prior state -> io_n=0x00, io_x=1, io_fired=0 immediately, without waiting for a clock edge.
- Idle selector: reset=1, io_en_a=12 for 3 cycles -> io_n=0x00, io_x=1, io_fired=0 throughout.
- Full cycle on node 1, io_en_a sequence 1, 4, 7, 10:
  - After Try (1): n[1]=T, io_n=0x04.
  - After Crit (4): n[1]=C, io_n=0x08, io_x=0.
  - After Exit (7): n[1]=E, io_n=0x0C.
  - After Idle (10): io_n=0x00, io_x=1.
  - io_fired=1 after each of the four steps.
- Contention, io_en_a sequence 0, 1, 3, 4:
  - After 0 and 1: nodes 0 and 1 are in T.
  - After 3: node 0 enters C, x=0.
  - Then 4: guard fails, n[1] stays T, io_fired=0, io_inv_ok=1.
- Disabled guards: from init, io_en_a=6 (Exit node 0) and io_en_a=9 (Idle node 0) -> no state change, io_fired=0.
- Mid-operation reset: drive node 2 into C, then pulse reset=0 between clock edges -> immediate init state. Random selector stress for 10k cycles afterwards -> io_inv_ok never 0.
